// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 channel mux.
package mux_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  // Select/grant width: ceil(log2(n)), never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted req strictly after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan ptr+1 .. ptr+N; the first hit wins, so ptr itself has lowest priority.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = SEL_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-input registered selector with valid/ready on every channel.
// Channel chosen by explicit sel or by round-robin over in_valid.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int SEL_W   = clog2_min1(N),
  parameter int RR_MODE = MUX_MODE_SEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     grant,
  output logic                 sel_err
);

  localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

  logic [N-1:0][WIDTH-1:0] ch;
  logic                    can_load;
  logic                    pick_found;
  logic [SEL_W-1:0]        pick_idx;
  logic                    sel_bad;
  logic                    xfer;

  assign ch = in_data;

  // Single-entry register that may drain and reload in the same cycle.
  // Gating with rst_n keeps every in_ready low while reset is held.
  assign can_load = rst_n && (!out_valid || out_ready);

  // Out-of-range select only exists when N is not a power of two.
  assign sel_bad = (RR_MODE == MUX_MODE_SEL) && ({1'b0, sel} >= N_L);

  generate
    if (RR_MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;

      rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
      );

      // Pointer remembers the last winner; reset value makes channel 0 first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= SEL_W'(N - 1);
        else if (xfer) ptr <= pick_idx;
      end
    end else begin : g_sel
      assign pick_found = !sel_bad;
      assign pick_idx   = sel;
    end
  endgenerate

  assign xfer = pick_found && can_load && in_valid[pick_idx];

  // Only the chosen channel sees ready; stalls and bad selects give none.
  always_comb begin
    in_ready = '0;
    if (can_load && pick_found) in_ready[pick_idx] = 1'b1;
  end

  // Output stage: load on transfer, clear valid on a plain drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
    end else if (xfer) begin
      out_data  <= ch[pick_idx];
      out_valid <= 1'b1;
      grant     <= pick_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle error pulse for a bad select seen while the register could load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= sel_bad && can_load;
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: three instances (N=4 select, N=3 select, N=4 round-robin)
// driven together and compared each cycle against a transaction-level model.
module tb_mux_n_reg;

  logic clk, rst_n;

  logic [3:0][31:0] d0, d2;
  logic [2:0][31:0] d1;
  logic [3:0] iv0, iv2, rdy0, rdy2;
  logic [2:0] iv1, rdy1;
  logic [1:0] sel0, sel1, sel2, gr0, gr1, gr2;
  logic ordy0, ordy1, ordy2, ov0, ov1, ov2, er0, er1, er2;
  logic [31:0] od0, od1, od2;

  mux_n_reg #(.WIDTH(32), .N(4), .RR_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(iv0), .in_ready(rdy0),
    .sel(sel0), .out_data(od0), .out_valid(ov0), .out_ready(ordy0),
    .grant(gr0), .sel_err(er0));

  mux_n_reg #(.WIDTH(32), .N(3), .RR_MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(iv1), .in_ready(rdy1),
    .sel(sel1), .out_data(od1), .out_valid(ov1), .out_ready(ordy1),
    .grant(gr1), .sel_err(er1));

  mux_n_reg #(.WIDTH(32), .N(4), .RR_MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(iv2), .in_ready(rdy2),
    .sel(sel2), .out_data(od2), .out_valid(ov2), .out_ready(ordy2),
    .grant(gr2), .sel_err(er2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        ov;
    bit [31:0] od;
    bit [3:0]  gr;
    int        ptr;
    bit        err;
  } mdl_t;

  mdl_t m0, m1, m2;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset(input int n);
    mdl_t m;
    m.ov = 0; m.od = 0; m.gr = 0; m.ptr = n - 1; m.err = 0;
    return m;
  endfunction

  // One clock of the reference: which channel is offered ready, what the register holds next.
  function automatic void step(input int n, input bit rr, input mdl_t m,
                               input bit [3:0] iv, input logic [3:0][31:0] id,
                               input int sel, input bit ordy,
                               output bit [3:0] rdy, output mdl_t nm);
    bit cl;
    int chn;
    cl  = !m.ov || ordy;
    chn = -1;
    nm  = m;
    nm.err = 0;
    rdy = '0;
    if (!rr) begin
      if (sel < n) chn = sel;
      else         nm.err = cl;
    end else begin
      for (int k = 1; k <= n; k++)
        if (chn < 0 && iv[(m.ptr + k) % n]) chn = (m.ptr + k) % n;
    end
    if (chn >= 0 && cl) rdy[chn] = 1'b1;
    if (chn >= 0 && cl && iv[chn]) begin
      nm.ov = 1; nm.od = id[chn]; nm.gr = 4'(chn);
      if (rr) nm.ptr = chn;
    end else if (ordy) begin
      nm.ov = 0;
    end
  endfunction

  // Called at a negedge with inputs applied; checks, advances one clock, returns at next negedge.
  task automatic cyc();
    bit [3:0] r0, r1, r2;
    mdl_t n0, n1, n2;
    check("ov0", ov0, m0.ov); check("od0", od0, m0.od); check("gr0", gr0, m0.gr); check("err0", er0, m0.err);
    check("ov1", ov1, m1.ov); check("od1", od1, m1.od); check("gr1", gr1, m1.gr); check("err1", er1, m1.err);
    check("ov2", ov2, m2.ov); check("od2", od2, m2.od); check("gr2", gr2, m2.gr); check("err2", er2, m2.err);
    step(4, 0, m0, iv0, d0, int'(sel0), ordy0, r0, n0);
    step(3, 0, m1, {1'b0, iv1}, {32'h0, d1}, int'(sel1), ordy1, r1, n1);
    step(4, 1, m2, iv2, d2, 0, ordy2, r2, n2);
    #1;
    check("rdy0", rdy0, r0); check("rdy1", rdy1, r1[2:0]); check("rdy2", rdy2, r2);
    @(posedge clk);
    m0 = n0; m1 = n1; m2 = n2;
    @(negedge clk);
  endtask

  int rr_all[5]  = '{0, 1, 2, 3, 0};
  int rr_odd[4]  = '{1, 3, 1, 3};

  initial begin
    rst_n = 0;
    d0 = '0; d1 = '0; d2 = '0;
    iv0 = '0; iv1 = '0; iv2 = '0;
    sel0 = '0; sel1 = '0; sel2 = '0;
    ordy0 = 0; ordy1 = 0; ordy2 = 0;
    m0 = mdl_reset(4); m1 = mdl_reset(3); m2 = mdl_reset(4);

    // reset values, and no ready while held even with valid inputs
    repeat (2) @(negedge clk);
    iv0 = 4'hF; iv2 = 4'hF; iv1 = 3'h7;
    #1;
    check("rst_ov", ov0, 0); check("rst_od", od0, 0); check("rst_gr", gr0, 0); check("rst_err", er0, 0);
    check("rst_rdy0", rdy0, 0); check("rst_rdy1", rdy1, 0); check("rst_rdy2", rdy2, 0);
    @(negedge clk);
    iv0 = '0; iv1 = '0; iv2 = '0;
    rst_n = 1;

    // explicit select of ch2
    sel0 = 2; d0[2] = 32'hDEADBEEF; iv0 = 4'b0100; ordy0 = 1;
    #1 check("sel_rdy", rdy0, 4'b0100);
    cyc();
    check("sel_od", od0, 32'hDEADBEEF); check("sel_ov", ov0, 1); check("sel_gr", gr0, 2);

    // backpressure: 0x11 held for three stalled cycles, then 0x22 loads without a bubble
    sel0 = 0; d0[0] = 32'h11; iv0 = 4'b0001; ordy0 = 1;
    cyc();
    ordy0 = 0; sel0 = 1; d0[1] = 32'h22; iv0 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_rdy", rdy0, 0);
      cyc();
      check("bp_hold", od0, 32'h11);
    end
    ordy0 = 1;
    #1 check("bp_rel_rdy", rdy0, 4'b0010);
    cyc();
    check("bp_load", od0, 32'h22); check("bp_ov", ov0, 1);
    iv0 = '0;

    // out-of-range select on the 3-channel instance
    ordy1 = 1; sel1 = 0; iv1 = '0;
    cyc();
    sel1 = 3; iv1 = 3'b111;
    #1 check("oor_rdy", rdy1, 0);
    cyc();
    check("oor_err", er1, 1); check("oor_ov", ov1, 0);
    sel1 = 0; iv1 = '0;
    cyc();
    check("oor_pulse", er1, 0);

    // round-robin sequences
    iv2 = 4'hF; ordy2 = 1;
    for (int i = 0; i < 5; i++) begin cyc(); check("rr_all", gr2, rr_all[i]); end
    iv2 = 4'b1010;
    for (int i = 0; i < 4; i++) begin cyc(); check("rr_odd", gr2, rr_odd[i]); end
    iv2 = 4'b0100;
    for (int i = 0; i < 3; i++) begin cyc(); check("rr_single", gr2, 2); end
    iv2 = '0;

    // throughput: eight back-to-back transfers on ch0
    sel0 = 0; iv0 = 4'b0001; ordy0 = 1;
    for (int i = 0; i < 8; i++) begin
      d0[0] = 32'hA000_0000 + 32'(i);
      cyc();
      check("tput_ov", ov0, 1); check("tput_od", od0, 32'hA000_0000 + 32'(i));
    end

    // randomized traffic on all three instances
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) begin d0[c] = $urandom; d2[c] = $urandom; end
      for (int c = 0; c < 3; c++) d1[c] = $urandom;
      iv0 = 4'($urandom); iv1 = 3'($urandom); iv2 = 4'($urandom);
      sel0 = 2'($urandom); sel1 = 2'($urandom_range(0, 3)); sel2 = 2'($urandom);
      ordy0 = ($urandom_range(0, 3) != 0); ordy1 = ($urandom_range(0, 3) != 0);
      ordy2 = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // reset while a word is held and a new transfer is offered
    sel0 = 0; d0[0] = 32'h5555; iv0 = 4'b0001; ordy0 = 0;
    cyc();
    check("mid_ov_pre", ov0, 1);
    iv0 = 4'hF; sel0 = 1; ordy0 = 1;
    rst_n = 0;
    m0 = mdl_reset(4); m1 = mdl_reset(3); m2 = mdl_reset(4);
    #1;
    check("mid_ov", ov0, 0); check("mid_od", od0, 0); check("mid_gr", gr0, 0);
    check("mid_err", er0, 0); check("mid_rdy", rdy0, 0);
    @(negedge clk);
    rst_n = 1;
    iv0 = '0; iv1 = '0; iv2 = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
